// File: rtl/sort_fetch.sv
// sort_fetch -- upstream load stage of the hdl_sort action engine.
//
// On fetch_start, reads fetch_beat_num (clamped to 32) consecutive 128-byte
// beats from host memory. Each beat is requested with a single-beat AXI4 read
// burst. The returned data is assembled into fetch_data, with beat k in slice k.
// The vector is held stable, with fetch_done high, until the next accepted start.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   fetch_start          one-cycle start pulse (ignored while a fetch runs)
//   fetch_pasid          PASID, sampled at start, driven on ARUSER
//   fetch_start_addr     first beat address, sampled at start (128-B aligned)
//   fetch_beat_num       beat count, sampled at start, values > 32 clamp to 32
//   fetch_done           level: fetch complete, fetch_data valid
//   fetch_error          level: some beat of this fetch returned RRESP != OKAY
//   fetch_data           assembled beats
//   m_axi_ar*            AXI4 read address channel (single-beat INCR bursts)
//   m_axi_r*             AXI4 read data channel (rready tied high)
module sort_fetch #(
  parameter int ID_WIDTH        = 1,
  parameter int ARUSER_WIDTH    = 9,
  parameter int PASID_WIDTH     = 9,
  parameter int FETCH_WIDTH     = 32768,
  parameter int DATA_WIDTH      = 1024,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    fetch_start,
  output logic                    fetch_done,
  output logic                    fetch_error,
  input  logic [PASID_WIDTH-1:0]  fetch_pasid,
  input  logic [ADDR_WIDTH-1:0]   fetch_start_addr,
  input  logic [5:0]              fetch_beat_num,
  output logic [FETCH_WIDTH-1:0]  fetch_data,

  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [3:0]              m_axi_arcache,
  output logic                    m_axi_arlock,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,

  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int         NSLICE    = FETCH_WIDTH / DATA_WIDTH;
  localparam logic [5:0] MAX_BEATS = (NSLICE > 32) ? 6'd32 : 6'(NSLICE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [PASID_WIDTH-1:0] pasid_q;
  logic [5:0]             beats_q;
  logic [5:0]             ar_cnt;
  logic [5:0]             r_cnt;
  logic [3:0]             outstanding;

  logic [5:0]             beats_clamped;
  logic                   ar_hs;
  logic                   r_hs;

  // Responses arrive in order on a single ID, so RID and RLAST carry no
  // information for this engine.
  logic                   unused_rsig;

  always_comb begin
    beats_clamped = (fetch_beat_num > MAX_BEATS) ? MAX_BEATS : fetch_beat_num;
  end

  // AR requests are derived purely from registered state. Hence arvalid can
  // only fall after its own handshake advances ar_cnt/outstanding.
  always_comb begin
    m_axi_arvalid  = (state == ST_RUN) && (ar_cnt < beats_q) &&
                     (outstanding < 4'(MAX_OUTSTANDING));
    m_axi_araddr   = addr_q + (ADDR_WIDTH'(ar_cnt) << 7);
    m_axi_aruser   = ARUSER_WIDTH'(pasid_q);
    m_axi_arid     = '0;
    m_axi_arlen    = 8'd0;
    m_axi_arsize   = 3'd7;
    m_axi_arburst  = 2'b01;
    m_axi_arcache  = 4'd3;
    m_axi_arlock   = 1'b0;
    m_axi_arprot   = 3'd0;
    m_axi_arqos    = 4'd0;
    m_axi_arregion = 4'd0;
    m_axi_rready   = 1'b1;
  end

  always_comb begin
    ar_hs       = m_axi_arvalid && m_axi_arready;
    r_hs        = m_axi_rvalid && (state == ST_RUN);
    unused_rsig = ^{m_axi_rid, m_axi_rlast};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      pasid_q     <= '0;
      beats_q     <= '0;
      ar_cnt      <= '0;
      r_cnt       <= '0;
      outstanding <= '0;
      fetch_done  <= 1'b0;
      fetch_error <= 1'b0;
      fetch_data  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (fetch_start) begin
            addr_q      <= fetch_start_addr;
            pasid_q     <= fetch_pasid;
            beats_q     <= beats_clamped;
            ar_cnt      <= '0;
            r_cnt       <= '0;
            outstanding <= '0;
            fetch_error <= 1'b0;
            fetch_data  <= '0;
            if (beats_clamped == 6'd0) begin
              state      <= ST_DONE;
              fetch_done <= 1'b1;
            end else begin
              state      <= ST_RUN;
              fetch_done <= 1'b0;
            end
          end
        end

        ST_RUN: begin
          if (ar_hs) begin
            ar_cnt <= ar_cnt + 6'd1;
          end

          case ({ar_hs, r_hs})
            2'b10:   outstanding <= outstanding + 4'd1;
            2'b01:   if (outstanding != 4'd0) outstanding <= outstanding - 4'd1;
            default: outstanding <= outstanding;
          endcase

          if (r_hs) begin
            if (int'(r_cnt) < NSLICE) begin
              fetch_data[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
            end
            if (m_axi_rresp != 2'b00) begin
              fetch_error <= 1'b1;
            end
            r_cnt <= r_cnt + 6'd1;
          end

          // Completion is taken on the final R handshake itself. This makes
          // fetch_done, fetch_data and fetch_error all valid in the next cycle.
          if ((r_hs && (r_cnt + 6'd1 == beats_q)) || (r_cnt == beats_q)) begin
            state      <= ST_DONE;
            fetch_done <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_fetch.sv
module tb_sort_fetch;

  localparam int DW = 1024;
  localparam int FW = 32768;
  localparam int AW = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           fetch_start = 1'b0;
  logic           fetch_done;
  logic           fetch_error;
  logic [8:0]     fetch_pasid = '0;
  logic [AW-1:0]  fetch_start_addr = '0;
  logic [5:0]     fetch_beat_num = '0;
  logic [FW-1:0]  fetch_data;
  logic [0:0]     m_axi_arid;
  logic [AW-1:0]  m_axi_araddr;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize;
  logic [1:0]     m_axi_arburst;
  logic [3:0]     m_axi_arcache;
  logic           m_axi_arlock;
  logic [2:0]     m_axi_arprot;
  logic [3:0]     m_axi_arqos;
  logic [3:0]     m_axi_arregion;
  logic [8:0]     m_axi_aruser;
  logic           m_axi_arvalid;
  logic           m_axi_arready = 1'b1;
  logic [0:0]     m_axi_rid = '0;
  logic [DW-1:0]  m_axi_rdata = '0;
  logic [1:0]     m_axi_rresp = '0;
  logic           m_axi_rlast = 1'b1;
  logic           m_axi_rvalid = 1'b0;
  logic           m_axi_rready;

  always #5 clk = ~clk;

  sort_fetch #(
    .ID_WIDTH(1), .ARUSER_WIDTH(9), .PASID_WIDTH(9), .FETCH_WIDTH(FW),
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_start(fetch_start), .fetch_done(fetch_done), .fetch_error(fetch_error),
    .fetch_pasid(fetch_pasid), .fetch_start_addr(fetch_start_addr),
    .fetch_beat_num(fetch_beat_num), .fetch_data(fetch_data),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache), .m_axi_arlock(m_axi_arlock),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void check_slice(input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      for (int w = 0; w < DW/32; w++) begin
        if (act[w*32 +: 32] !== exp[w*32 +: 32]) begin
          $display("FAIL slice%0d word%0d: got %h expected %h", k, w, act[w*32 +: 32], exp[w*32 +: 32]);
          break;
        end
      end
    end
  endfunction

  // Beat payload: 32 copies of {tid, 0xC3, beat index}.
  function automatic logic [DW-1:0] mk(input int unsigned t, input int unsigned k);
    logic [31:0] w;
    logic [7:0]  tb8;
    logic [15:0] kb16;
    tb8  = t[7:0];
    kb16 = k[15:0];
    w    = {tb8, 8'hC3, kb16};
    return {32{w}};
  endfunction

  typedef struct {
    int beats;
    bit err;
  } res_t;

  logic [AW-1:0] ar_exp[$];
  res_t          res_exp[$];
  res_t          rr;

  // Slave / monitor state
  bit          mon_en = 1'b1;
  bit          force_r = 1'b0;
  bit          slow_ar = 1'b0;
  bit          armed = 1'b0;
  bit          first = 1'b0;
  int          pending = 0;
  int          ar_seen = 0;
  int          r_seen = 0;
  int          cur_beats = 0;
  int          hold = 0;
  int          err_beat = -1;
  int unsigned tid = 0;
  int unsigned cyc = 0;
  logic [8:0]  cur_pasid = '0;
  bit          prev_ar_hs = 1'b0;
  bit          prev_r_hs = 1'b0;
  bit          prev_ar_stall = 1'b0;
  logic [AW-1:0] prev_araddr = '0;
  logic [63:0]   ar_const;
  logic [63:0]   ar_const_exp;

  always @(negedge clk) begin
    cyc++;
    if (mon_en && rst_n) begin
      if (prev_ar_hs) pending++;
      if (prev_r_hs) begin
        pending--;
        r_seen++;
        check("done_lat", 64'(fetch_done), 64'(r_seen == cur_beats));
      end
      if (armed && first) begin
        first = 1'b0;
        if (cur_beats > 0) check("done_clr", 64'(fetch_done), 64'd0);
        else               check("zero_done", 64'(fetch_done), 64'd1);
      end
      if (armed && fetch_done) begin
        armed = 1'b0;
        if (res_exp.size() == 0) begin
          check("res_extra", 64'd1, 64'd0);
        end else begin
          rr = res_exp.pop_front();
          check("error", 64'(fetch_error), 64'(rr.err));
          check("ar_count", 64'(ar_seen), 64'(rr.beats));
          check("r_count", 64'(r_seen), 64'(rr.beats));
          for (int k = 0; k < 32; k++)
            check_slice(k, fetch_data[k*DW +: DW], (k < rr.beats) ? mk(tid, k) : '0);
        end
      end
      if (hold > 0) hold--;

      m_axi_arready = !(slow_ar && (cyc % 3 == 1));
      m_axi_rvalid  = force_r || (pending > 0 && hold == 0);
      m_axi_rdata   = mk(tid, r_seen);
      m_axi_rresp   = (r_seen == err_beat) ? 2'd2 : 2'd0;

      if (prev_ar_stall) begin
        check("ar_hold", 64'(m_axi_arvalid), 64'd1);
        check("ar_stable", m_axi_araddr, prev_araddr);
      end
      if (pending > 8) check("outst_le8", 64'(pending), 64'd8);
      check("rready", 64'(m_axi_rready), 64'd1);
      if (m_axi_arvalid && m_axi_arready) begin
        if (ar_exp.size() == 0) begin
          check("ar_extra", m_axi_araddr, '1);
        end else begin
          check("araddr", m_axi_araddr, ar_exp.pop_front());
          check("aruser", 64'(m_axi_aruser), 64'(cur_pasid));
          ar_const = 64'({m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache,
                          m_axi_arlock, m_axi_arprot, m_axi_arqos, m_axi_arregion});
          check("ar_const", ar_const, ar_const_exp);
        end
        ar_seen++;
      end
      prev_ar_hs    = m_axi_arvalid && m_axi_arready;
      prev_ar_stall = m_axi_arvalid && !m_axi_arready;
      prev_araddr   = m_axi_araddr;
      prev_r_hs     = m_axi_rvalid && m_axi_rready;
    end else begin
      prev_ar_hs    = 1'b0;
      prev_ar_stall = 1'b0;
      prev_r_hs     = 1'b0;
      pending       = 0;
      m_axi_rvalid  = force_r;
      m_axi_rdata   = mk(8'hEE, 0);
      m_axi_rresp   = force_r ? 2'd2 : 2'd0;
    end
  end

  task automatic start(input int unsigned t, input logic [AW-1:0] a, input logic [5:0] bn,
                       input int exp_beats, input bit exp_err, input int hold_c, input int errb);
    @(negedge clk);
    fetch_start      = 1'b1;
    fetch_start_addr = a;
    fetch_beat_num   = bn;
    fetch_pasid      = 9'(t * 3 + 1);
    @(posedge clk);
    #1;
    fetch_start = 1'b0;
    tid         = t;
    cur_pasid   = 9'(t * 3 + 1);
    cur_beats   = exp_beats;
    ar_seen     = 0;
    r_seen      = 0;
    hold        = hold_c;
    err_beat    = errb;
    for (int i = 0; i < exp_beats; i++) ar_exp.push_back(a + 64'(i) * 64'd128);
    res_exp.push_back('{exp_beats, exp_err});
    first = 1'b1;
    armed = 1'b1;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    int c;
    c = 0;
    while (armed && c < maxc) begin
      @(posedge clk);
      c++;
    end
    if (armed) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: fetch_done not seen within %0d cycles", nm, maxc);
      armed = 1'b0;
    end
  endtask

  logic [AW-1:0] t1a [4];

  initial begin
    ar_const_exp = 64'({1'b0, 8'd0, 3'd7, 2'd1, 4'd3, 1'b0, 3'd0, 4'd0, 4'd0});
    t1a = '{64'h1000, 64'h1080, 64'h1100, 64'h1180};

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_done", 64'(fetch_done), 64'd0);
    check("rst_err", 64'(fetch_error), 64'd0);
    check("rst_data_zero", 64'(fetch_data == '0), 64'd1);
    check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_araddr", m_axi_araddr, 64'd0);
    check("rst_aruser", 64'(m_axi_aruser), 64'd0);
    check("rst_rready", 64'(m_axi_rready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 4 beats at 0x1000, zero-wait slave
    start(1, 64'h1000, 6'd4, 4, 1'b0, 0, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("t1_arvalid", 64'(m_axi_arvalid), 64'd1);
      check("t1_araddr", m_axi_araddr, t1a[i]);
    end
    @(negedge clk);
    #1;
    check("t1_arvalid_off", 64'(m_axi_arvalid), 64'd0);
    wait_done(50, "t1");

    // zero beats: done in cycle 1, no AR
    start(2, 64'h5000, 6'd0, 0, 1'b0, 0, -1);
    wait_done(10, "t2");
    repeat (3) @(negedge clk);

    // 32 beats, R withheld for 20 cycles
    start(3, 64'h40000, 6'd32, 32, 1'b0, 20, -1);
    repeat (18) @(posedge clk);
    #1;
    check("t3_ar_issued", 64'(ar_seen), 64'd8);
    check("t3_pending", 64'(pending), 64'd8);
    check("t3_arvalid_lim", 64'(m_axi_arvalid), 64'd0);
    wait_done(300, "t3");

    // 3 beats, beat 1 errors; next start clears the error
    start(4, 64'h8000, 6'd3, 3, 1'b1, 0, 1);
    wait_done(50, "t4");
    start(5, 64'h9000, 6'd0, 0, 1'b0, 0, -1);
    wait_done(10, "t4b");

    // 40 beats clamp to 32, stalling arready, address wraps past 2^64
    slow_ar = 1'b1;
    start(6, 64'hFFFF_FFFF_FFFF_FF00, 6'd40, 32, 1'b0, 0, -1);
    wait_done(400, "t5");
    slow_ar = 1'b0;
    repeat (4) @(negedge clk);

    // start ignored during RUN, then async reset with R beats still arriving
    start(7, 64'h2000_0000, 6'd8, 8, 1'b0, 0, -1);
    repeat (2) @(negedge clk);
    fetch_start      = 1'b1;
    fetch_start_addr = 64'hDEAD_0000;
    fetch_beat_num   = 6'd1;
    fetch_pasid      = 9'h1FF;
    @(posedge clk);
    #1 fetch_start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    mon_en  = 1'b0;
    force_r = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("mid_rst_done", 64'(fetch_done), 64'd0);
    check("mid_rst_err", 64'(fetch_error), 64'd0);
    check("mid_rst_data_zero", 64'(fetch_data == '0), 64'd1);
    check("mid_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("mid_rst_araddr", m_axi_araddr, 64'd0);
    check("mid_rst_aruser", 64'(m_axi_aruser), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    check("stray_done", 64'(fetch_done), 64'd0);
    check("stray_err", 64'(fetch_error), 64'd0);
    check("stray_data_zero", 64'(fetch_data == '0), 64'd1);
    check("stray_arvalid", 64'(m_axi_arvalid), 64'd0);
    force_r = 1'b0;
    ar_exp.delete();
    res_exp.delete();
    armed = 1'b0;
    first = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 1'b1;

    // recovery fetch after reset
    start(8, 64'h3000, 6'd2, 2, 1'b0, 0, -1);
    wait_done(50, "t6");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
